// File: rtl/bp_bootrom_arb_pkg.sv
// Shared types and constants for the bootrom request arbiter.
// Ports: none (package).
package bp_bootrom_arb_pkg;

    typedef enum logic [2:0] {
        eIdle,
        eIssue,
        eWait,
        eErr,
        eDrain
    } bp_bootrom_arb_state_e;

    // Data bit replicated across the response bus on a timeout error.
    localparam logic bp_bootrom_err_data_bit_lp = 1'b0;

    // clog2 that never returns a zero-width result.
    function automatic int bp_bootrom_safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter: search starts one past the last consumed grant.
// Ports: clk_i, reset_i, grants_en_i, reqs_i, yumi_i -> grants_o, v_o, tag_o.
module bsg_arb_round_robin #(
    parameter int width_p = 2,
    localparam int lg_width_lp = (width_p <= 1) ? 1 : $clog2(width_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   grants_en_i,
    input  logic [width_p-1:0]     reqs_i,
    output logic [width_p-1:0]     grants_o,
    output logic                   v_o,
    output logic [lg_width_lp-1:0] tag_o,
    input  logic                   yumi_i
);

    localparam logic [lg_width_lp-1:0] last_rst_lp = lg_width_lp'(width_p - 1);

    logic [lg_width_lp-1:0] last_r;
    logic [lg_width_lp-1:0] idx;

    always_comb begin
        grants_o = '0;
        v_o      = 1'b0;
        tag_o    = '0;
        idx      = '0;
        for (int i = 0; i < width_p; i++) begin
            idx = lg_width_lp'((int'(last_r) + 1 + i) % width_p);
            if (!v_o && reqs_i[idx]) begin
                v_o           = 1'b1;
                tag_o         = idx;
                grants_o[idx] = 1'b1;
            end
        end
        if (!grants_en_i) begin
            grants_o = '0;
            v_o      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_r <= last_rst_lp;
        end else if (yumi_i) begin
            last_r <= tag_o;
        end
    end

endmodule

// File: rtl/bsg_dff_reset_en.sv
// Enabled register with asynchronous active-high reset to a constant.
// Ports: clk_i, reset_i, en_i, data_i[width_p] -> data_o[width_p].
module bsg_dff_reset_en #(
    parameter int width_p = 1,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_o <= reset_val_p;
        end else if (en_i) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/bp_bootrom_req_arbiter.sv
// Shares one FIFO-style bootrom read port among num_req_p requesters,
// one transaction at a time, with a watchdog that errors out stalls.
// Ports:
//   req_addr_i/req_size_i/req_v_i -> req_yumi_o   : per-requester requests
//   resp_data_o/resp_err_o/resp_v_o <- resp_ready_and_i : routed responses
//   mem_addr_o/mem_size_o/mem_v_o <- mem_yumi_i   : request to bootrom
//   mem_data_i/mem_v_i -> mem_ready_and_o          : response from bootrom
module bp_bootrom_req_arbiter
    import bp_bootrom_arb_pkg::*;
#(
    parameter int num_req_p        = 2,
    parameter int addr_width_p     = 64,
    parameter int data_width_p     = 64,
    parameter int timeout_cycles_p = 1024
) (
    input  logic                              clk_i,
    input  logic                              reset_i,

    input  logic [num_req_p*addr_width_p-1:0] req_addr_i,
    input  logic [num_req_p*3-1:0]            req_size_i,
    input  logic [num_req_p-1:0]              req_v_i,
    output logic [num_req_p-1:0]              req_yumi_o,

    output logic [data_width_p-1:0]           resp_data_o,
    output logic                              resp_err_o,
    output logic [num_req_p-1:0]              resp_v_o,
    input  logic [num_req_p-1:0]              resp_ready_and_i,

    output logic [addr_width_p-1:0]           mem_addr_o,
    output logic [2:0]                        mem_size_o,
    output logic                              mem_v_o,
    input  logic                              mem_yumi_i,

    input  logic [data_width_p-1:0]           mem_data_i,
    input  logic                              mem_v_i,
    output logic                              mem_ready_and_o
);

    localparam int lg_req_lp = bp_bootrom_safe_clog2(num_req_p);
    localparam int cnt_w_lp  = bp_bootrom_safe_clog2(timeout_cycles_p + 1);
    localparam int latch_w_lp = lg_req_lp + addr_width_p + 3;

    localparam logic [cnt_w_lp-1:0] cnt_last_lp =
        cnt_w_lp'((timeout_cycles_p == 0) ? 0 : timeout_cycles_p - 1);
    localparam logic [cnt_w_lp-1:0] cnt_max_lp = '1;

    bp_bootrom_arb_state_e state_r, state_n;

    logic [cnt_w_lp-1:0]     cnt_r;
    logic [num_req_p-1:0]    arb_grants;
    logic                    arb_v;
    logic [lg_req_lp-1:0]    arb_tag;
    logic                    idle_fire;

    logic [addr_width_p-1:0] sel_addr;
    logic [2:0]              sel_size;
    logic [latch_w_lp-1:0]   latch_d, latch_q;

    logic [lg_req_lp-1:0]    gnt_r;
    logic [addr_width_p-1:0] addr_r;
    logic [2:0]              size_r;
    logic [num_req_p-1:0]    gnt_one_hot;

    logic                    gnt_ready;
    logic                    wait_hs;
    logic                    expire;

    assign idle_fire = (state_r == eIdle) && arb_v;

    // The pointer advances when the grant is consumed; with only one
    // transaction in flight this matches advancing at completion.
    bsg_arb_round_robin #(
        .width_p(num_req_p)
    ) rr (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .grants_en_i(state_r == eIdle),
        .reqs_i     (req_v_i),
        .grants_o   (arb_grants),
        .v_o        (arb_v),
        .tag_o      (arb_tag),
        .yumi_i     (idle_fire)
    );

    assign sel_addr = req_addr_i[int'(arb_tag)*addr_width_p +: addr_width_p];
    assign sel_size = req_size_i[int'(arb_tag)*3 +: 3];
    assign latch_d  = {arb_tag, sel_addr, sel_size};

    bsg_dff_reset_en #(
        .width_p(latch_w_lp)
    ) req_latch (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .en_i   (idle_fire),
        .data_i (latch_d),
        .data_o (latch_q)
    );

    assign {gnt_r, addr_r, size_r} = latch_q;

    assign gnt_one_hot = num_req_p'(1) << gnt_r;
    assign gnt_ready   = |(resp_ready_and_i & gnt_one_hot);
    assign wait_hs     = mem_v_i && gnt_ready;
    assign expire      = (timeout_cycles_p != 0) && (cnt_r == cnt_last_lp);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= eIdle;
        end else begin
            state_r <= state_n;
        end
    end

    // Cleared on issue, counts every eWait cycle without a handshake.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_r <= '0;
        end else if (state_r == eIssue && mem_yumi_i) begin
            cnt_r <= '0;
        end else if (state_r == eWait && !wait_hs && cnt_r != cnt_max_lp) begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    always_comb begin
        state_n = state_r;
        unique case (state_r)
            eIdle: begin
                if (arb_v) state_n = eIssue;
            end
            eIssue: begin
                if (mem_yumi_i) state_n = eWait;
            end
            eWait: begin
                // A handshake on the expiry cycle beats the watchdog.
                if (wait_hs) begin
                    state_n = eIdle;
                end else if (expire) begin
                    state_n = eErr;
                end
            end
            eErr: begin
                if (gnt_ready) state_n = eDrain;
            end
            eDrain: begin
                if (mem_v_i) state_n = eIdle;
            end
            default: state_n = eIdle;
        endcase
    end

    always_comb begin
        req_yumi_o      = '0;
        resp_data_o     = '0;
        resp_err_o      = 1'b0;
        resp_v_o        = '0;
        mem_addr_o      = '0;
        mem_size_o      = '0;
        mem_v_o         = 1'b0;
        mem_ready_and_o = 1'b0;
        unique case (state_r)
            eIdle: begin
                req_yumi_o = arb_grants;
            end
            eIssue: begin
                mem_v_o    = 1'b1;
                mem_addr_o = addr_r;
                mem_size_o = size_r;
            end
            eWait: begin
                mem_ready_and_o = gnt_ready;
                resp_v_o        = mem_v_i ? gnt_one_hot : '0;
                resp_data_o     = mem_v_i ? mem_data_i : '0;
            end
            eErr: begin
                resp_v_o    = gnt_one_hot;
                resp_err_o  = 1'b1;
                resp_data_o = {data_width_p{bp_bootrom_err_data_bit_lp}};
            end
            eDrain: begin
                mem_ready_and_o = 1'b1;
            end
            default: begin
            end
        endcase
        // Outputs are forced quiet while reset is held.
        if (reset_i) begin
            req_yumi_o      = '0;
            resp_data_o     = '0;
            resp_err_o      = 1'b0;
            resp_v_o        = '0;
            mem_addr_o      = '0;
            mem_size_o      = '0;
            mem_v_o         = 1'b0;
            mem_ready_and_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_bp_bootrom_req_arbiter.sv
// Self-checking bench for bp_bootrom_req_arbiter (2 requesters, 8-cycle
// watchdog) with a transaction-level reference model.
module tb_bp_bootrom_req_arbiter;

    localparam int N  = 2;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            reset_i;
    logic [N*AW-1:0] req_addr;
    logic [N*3-1:0]  req_size;
    logic [N-1:0]    req_v;
    logic [N-1:0]    req_yumi;
    logic [DW-1:0]   resp_data;
    logic            resp_err;
    logic [N-1:0]    resp_v;
    logic [N-1:0]    resp_ready;
    logic [AW-1:0]   mem_addr;
    logic [2:0]      mem_size;
    logic            mem_v_o;
    logic            mem_yumi;
    logic [DW-1:0]   mem_data;
    logic            mem_v_in;
    logic            mem_ready;

    int checks = 0;
    int errors = 0;
    int rr_last;
    logic [AW-1:0] a_tab [N];
    logic [2:0]    s_tab [N];

    always #5 clk = ~clk;

    bp_bootrom_req_arbiter #(
        .num_req_p       (N),
        .addr_width_p    (AW),
        .data_width_p    (DW),
        .timeout_cycles_p(TO)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .req_addr_i      (req_addr),
        .req_size_i      (req_size),
        .req_v_i         (req_v),
        .req_yumi_o      (req_yumi),
        .resp_data_o     (resp_data),
        .resp_err_o      (resp_err),
        .resp_v_o        (resp_v),
        .resp_ready_and_i(resp_ready),
        .mem_addr_o      (mem_addr),
        .mem_size_o      (mem_size),
        .mem_v_o         (mem_v_o),
        .mem_yumi_i      (mem_yumi),
        .mem_data_i      (mem_data),
        .mem_v_i         (mem_v_in),
        .mem_ready_and_o (mem_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inv();
        chk("yumi_onehot", 64'($countones(req_yumi) <= 1), 64'd1);
        chk("respv_onehot", 64'($countones(resp_v) <= 1), 64'd1);
    endtask

    function automatic int rr_pick(input logic [N-1:0] m, input int last);
        for (int i = 1; i <= N; i++) begin
            if (m[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic set_reqs(input logic [N-1:0] m);
        for (int j = 0; j < N; j++) begin
            a_tab[j] = {$urandom, $urandom};
            s_tab[j] = 3'($urandom_range(0, 7));
            req_addr[j*AW +: AW] = a_tab[j];
            req_size[j*3 +: 3]   = s_tab[j];
        end
        req_v = m;
    endtask

    function automatic logic [N-1:0] rnd_ready(input int w, input logic b);
        logic [N-1:0] r;
        r    = N'($urandom);
        r[w] = b;
        return r;
    endfunction

    // yd: issue cycles before yumi; rd: wait cycles before mem_v;
    // bp: extra cycles the requester holds off; ed: error-hold cycles;
    // late: drain cycles before a never-sent response arrives.
    task automatic txn(input logic [N-1:0] mask, input bit keep,
                       input int yd, input int rd, input int bp,
                       input int ed, input int late,
                       input logic [DW-1:0] data,
                       output int cyc, output int win, output bit err);
        logic [N-1:0] w1h;
        bit           hs;
        bit           pend;
        cyc = 0;
        err = 1'b0;
        win = rr_pick(mask, rr_last);
        w1h = N'(1) << win;
        set_reqs(mask);
        mem_yumi   = 1'b0;
        mem_v_in   = 1'b0;
        resp_ready = '0;
        #1;
        chk("idle_yumi", 64'(req_yumi), 64'(w1h));
        chk("idle_memv", 64'(mem_v_o), 64'd0);
        chk("idle_respv", 64'(resp_v), 64'd0);
        inv();
        cyc++;
        tick();
        if (!keep) req_v = '0;
        for (int k = 0; k <= yd; k++) begin
            mem_yumi = (k == yd);
            #1;
            chk("issue_memv", 64'(mem_v_o), 64'd1);
            chk("issue_addr", mem_addr, a_tab[win]);
            chk("issue_size", 64'(mem_size), 64'(s_tab[win]));
            chk("issue_yumi", 64'(req_yumi), 64'd0);
            cyc++;
            tick();
        end
        mem_yumi = 1'b0;
        mem_data = data;
        hs       = 1'b0;
        for (int c = 0; c < TO; c++) begin
            mem_v_in   = (c >= rd);
            resp_ready = rnd_ready(win, c >= rd + bp);
            #1;
            hs = mem_v_in && (c >= rd + bp);
            chk("wait_respv", 64'(resp_v), mem_v_in ? 64'(w1h) : 64'd0);
            chk("wait_data", resp_data, mem_v_in ? data : 64'd0);
            chk("wait_err", 64'(resp_err), 64'd0);
            chk("wait_mready", 64'(mem_ready), 64'(c >= rd + bp));
            chk("wait_yumi", 64'(req_yumi), 64'd0);
            inv();
            cyc++;
            tick();
            if (hs) break;
        end
        if (!hs) begin
            err  = 1'b1;
            pend = mem_v_in;
            for (int e = 0; e <= ed; e++) begin
                resp_ready = rnd_ready(win, e == ed);
                #1;
                chk("err_respv", 64'(resp_v), 64'(w1h));
                chk("err_flag", 64'(resp_err), 64'd1);
                chk("err_data", resp_data, 64'd0);
                chk("err_mready", 64'(mem_ready), 64'd0);
                inv();
                cyc++;
                tick();
            end
            for (int d = 0; d < 16; d++) begin
                mem_v_in   = pend || (d >= late);
                mem_data   = {$urandom, $urandom};
                resp_ready = N'($urandom);
                #1;
                chk("drain_respv", 64'(resp_v), 64'd0);
                chk("drain_mready", 64'(mem_ready), 64'd1);
                chk("drain_data", resp_data, 64'd0);
                chk("drain_err", 64'(resp_err), 64'd0);
                cyc++;
                tick();
                if (mem_v_in) break;
            end
        end
        req_v      = '0;
        mem_v_in   = 1'b0;
        resp_ready = '0;
        rr_last    = win;
    endtask

    initial begin
        int  cyc;
        int  win;
        bit  err;
        logic [DW-1:0] d;

        reset_i    = 1'b1;
        req_addr   = '0;
        req_size   = '0;
        req_v      = 2'b11;
        mem_yumi   = 1'b0;
        mem_data   = '0;
        mem_v_in   = 1'b1;
        resp_ready = 2'b11;
        rr_last    = N - 1;
        #2;
        chk("rst_yumi", 64'(req_yumi), 64'd0);
        chk("rst_memv", 64'(mem_v_o), 64'd0);
        chk("rst_respv", 64'(resp_v), 64'd0);
        chk("rst_mready", 64'(mem_ready), 64'd0);
        tick();
        tick();
        reset_i  = 1'b0;
        req_v    = '0;
        mem_v_in = 1'b0;

        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom};
            txn(2'b11, 1'b1, 1, 1, 0, 0, 0, d, cyc, win, err);
            chk("contention_order", 64'(win), 64'(i % 2));
        end

        txn(2'b01, 1'b0, 0, 0, 0, 0, 0, 64'hDEADBEEF_00000001, cyc, win, err);
        chk("single_win", 64'(win), 64'd0);
        chk("single_cycles", 64'(cyc), 64'd3);
        chk("single_noerr", 64'(err), 64'd0);

        d = {$urandom, $urandom};
        txn(2'b10, 1'b0, 0, 0, 5, 0, 0, d, cyc, win, err);
        chk("bp_cycles", 64'(cyc), 64'd8);
        chk("bp_noerr", 64'(err), 64'd0);

        d = {$urandom, $urandom};
        txn(2'b01, 1'b0, 0, 100, 0, 0, 2, d, cyc, win, err);
        chk("timeout_err", 64'(err), 64'd1);
        chk("timeout_cycles", 64'(cyc), 64'd14);

        d = {$urandom, $urandom};
        txn(2'b01, 1'b0, 0, 7, 0, 0, 0, d, cyc, win, err);
        chk("race_noerr", 64'(err), 64'd0);
        chk("race_cycles", 64'(cyc), 64'd10);

        d = {$urandom, $urandom};
        txn(2'b11, 1'b0, 0, 6, 2, 1, 0, d, cyc, win, err);
        chk("pend_timeout_err", 64'(err), 64'd1);

        for (int i = 0; i < 24; i++) begin
            logic [N-1:0] m;
            m = N'($urandom_range(1, 3));
            d = {$urandom, $urandom};
            txn(m, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 10),
                $urandom_range(0, 3), $urandom_range(0, 2),
                $urandom_range(0, 3), d, cyc, win, err);
        end

        set_reqs(2'b10);
        #1;
        chk("mid_grant", 64'(req_yumi), 64'b10);
        tick();
        req_v    = '0;
        mem_yumi = 1'b1;
        tick();
        mem_yumi   = 1'b0;
        req_v      = 2'b11;
        mem_v_in   = 1'b1;
        resp_ready = 2'b00;
        #1;
        chk("mid_wait_respv", 64'(resp_v), 64'b10);
        reset_i    = 1'b1;
        resp_ready = 2'b11;
        #1;
        chk("mid_rst_respv", 64'(resp_v), 64'd0);
        chk("mid_rst_yumi", 64'(req_yumi), 64'd0);
        chk("mid_rst_mready", 64'(mem_ready), 64'd0);
        chk("mid_rst_data", resp_data, 64'd0);
        tick();
        reset_i    = 1'b0;
        req_v      = '0;
        mem_v_in   = 1'b0;
        resp_ready = '0;
        rr_last    = N - 1;
        d = {$urandom, $urandom};
        txn(2'b11, 1'b0, 0, 0, 0, 0, 0, d, cyc, win, err);
        chk("post_rst_prio", 64'(win), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_bootrom_req_arbiter.md
Name: bp_bootrom_req_arbiter

Overview:
- Shares one FIFO-style bootrom read port (addr/size/v/yumi request, data/v/ready_and response) among num_req_p requesters, e.g. boot CPU and debug module.
- Round-robin grant, one outstanding transaction, and the response is routed back to the granted requester.
- A watchdog returns an error response if the bootrom stalls, then drains the late response.
- Sits between requesters and the bootrom's AXI-to-FIFO request side.

Parameters:
- num_req_p, 2, number of requesters (>=1).
- addr_width_p, 64, request address width.
- data_width_p, 64, response data width.
- timeout_cycles_p, 1024, cycles in eWait before error response; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous active-high reset.
- req_addr_i  in  num_req_p*addr_width_p  per-requester address, requester i at slice i.
- req_size_i  in  num_req_p*3  per-requester AXI-encoded size.
- req_v_i  in  num_req_p  request valid.
- req_yumi_o  out  num_req_p  request consumed; one-hot or zero.
- resp_data_o  out  data_width_p  response data, shared by all requesters.
- resp_err_o  out  1  response is a timeout error.
- resp_v_o  out  num_req_p  response valid; one-hot or zero.
- resp_ready_and_i  in  num_req_p  requester ready.
- mem_addr_o  out  addr_width_p  address to bootrom.
- mem_size_o  out  3  size to bootrom.
- mem_v_o  out  1  request valid to bootrom.
- mem_yumi_i  in  1  bootrom consumed the request.
- mem_data_i  in  data_width_p  bootrom response data.
- mem_v_i  in  1  bootrom response valid.
- mem_ready_and_o  out  1  ready for bootrom response.

Behaviour:
- Reset: asynchronous, active-high, single clock. On reset, state=eIdle, counter=0, last_grant=num_req_p-1 (requester 0 has highest priority first). All outputs are 0 during reset.
- eIdle:
  - If any req_v_i, pick the winner g round-robin, starting from (last_grant+1) mod num_req_p.
  - In the same cycle: req_yumi_o[g]=1; latch g, addr and size; go to eIssue.
  - No request is consumed in any other state.
- eIssue:
  - mem_v_o=1 with the latched addr/size, held stable until mem_yumi_i.
  - On mem_yumi_i: counter cleared, go to eWait.
  - No timeout runs in eIssue; a request is never retracted.
- eWait:
  - Routing is combinational, zero latency: mem_ready_and_o=resp_ready_and_i[g]; resp_v_o[g]=mem_v_i; resp_data_o=mem_data_i; resp_err_o=0.
  - On mem_v_i & resp_ready_and_i[g]: last_grant<=g, go to eIdle.
  - Otherwise the counter increments, saturating, width clog2(timeout_cycles_p+1).
  - If timeout_cycles_p!=0 and counter==timeout_cycles_p-1 with no handshake this cycle: go to eErr.
  - Handshake in the same cycle the counter would expire: the handshake wins; no error, go to eIdle.
  - mem_v_i while requester g is not ready: response is held off and the counter keeps running. If timeout fires while mem_v_i=1 but not accepted, go to eErr and then eDrain.
- eErr:
  - resp_v_o[g]=1, resp_data_o=0, resp_err_o=1, mem_ready_and_o=0.
  - On resp_ready_and_i[g]: last_grant<=g, go to eDrain.
- eDrain:
  - mem_ready_and_o=1; all resp_v_o=0.
  - On mem_v_i: discard the data, go to eIdle.
- Invariant: at most one bit of resp_v_o and one bit of req_yumi_o is set per cycle.
- Reset mid-transaction: abandons everything. A bootrom response arriving after reset is outside this block's contract; the bootrom is reset together with it.
- resp_data_o=0 whenever no response is being presented.
- Throughput: one transaction every 3 cycles minimum (Idle, Issue, Wait with immediate response).

Decomposition:
- Package bp_bootrom_arb_pkg: state enum bp_bootrom_arb_state_e {eIdle, eIssue, eWait, eErr, eDrain}, and error data constant (zero).
- Round-robin selection reuses bsg_arb_round_robin (width num_req_p), with its yumi driven by the eIdle grant.
- Latches use bsg_dff_reset_en; FSM and counter are local always_ff blocks with asynchronous reset.

Test Plan:
- Single requester: req 0 reads addr 0x10, bootrom yumi next cycle and data 0xDEADBEEF_00000001 the cycle after → resp_v_o=01, data matches, resp_err_o=0, total 3 cycles.
- Contention: both req_v_i held high for 4 transactions → grant order 0,1,0,1; req_yumi_o never 11.
- Backpressure: mem_v_i=1 while resp_ready_and_i[g]=0 for 5 cycles → mem_ready_and_o=0 and data stable; completes when ready rises.
- Timeout: timeout_cycles_p=8, bootrom never responds → after 8 cycles in eWait, resp_v_o[g]=1, resp_err_o=1, data=0. A late mem_v_i is then drained with no resp_v_o, and the next request is served normally.
- Race: response on the exact expiry cycle → normal response, resp_err_o=0, no eDrain.
- Asynchronous reset asserted in eWait mid-cycle → outputs zero immediately; after release, req 0 has priority.
